// File: rtl/cal_lut_serial_loader_pkg.sv
// Shared constants for the calibration-LUT loader: LUT geometry and FSM state codes.
// Entry count tracks the sensor's VDAC resolution so both sides agree on LUT size.
package cal_lut_pkg;

    localparam int N_VDAC    = 6;
    localparam int N_LUT     = 6;
    localparam int N_ENTRIES = 2 ** (N_VDAC - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_HI   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/cal_lut_serial_loader_if.sv
// Control and entry stream between configuration logic (master) and the LUT loader (slave).
// in_valid/in_ready is a plain valid-ready handshake; start/abort are single-cycle strobes.
interface cal_lut_serial_loader_if;
    import cal_lut_pkg::*;

    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [N_LUT-1:0] in_data;

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready
    );

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready
    );

endinterface

// File: rtl/cal_lut_serial_loader_half_timer.sv
// Down-counter timing one cal_clk phase; reloaded on each LO/HI entry, o_tc marks the phase's last cycle.
// No backpressure: counts every clk while enabled, holds at zero otherwise.
module cal_half_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(HALF_PERIOD + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(HALF_PERIOD - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/cal_lut_serial_loader.sv
// Serializes 32 six-bit LUT entries MSB-first onto cal_clk/cal_dat, then raises cal_ena; 1+12*HALF_PERIOD cycles per entry.
// Backpressure: in_ready only while waiting for the next entry; a stall parks cal_clk low indefinitely.
module cal_lut_serial_loader
    import cal_lut_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    cal_lut_serial_loader_if.slave  i_cfg,
    output logic                    o_cal_clk,
    output logic                    o_cal_dat,
    output logic                    o_cal_ena,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BIT_W = $clog2(N_LUT);
    localparam int IDX_W = $clog2(N_ENTRIES);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [N_LUT-1:0] r_shreg;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [IDX_W-1:0] r_entry_idx;
    logic             r_cal_clk;
    logic             r_cal_dat;
    logic             r_cal_ena;
    logic             r_busy;
    logic             r_done;

    logic w_tc;
    logic w_tmr_en;
    logic w_tmr_load;
    logic w_launch;
    logic w_accept;
    logic w_shift;
    logic w_next_entry;
    logic w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_cfg.start && !i_cfg.abort) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_cfg.abort)         w_state_nxt = ST_IDLE;
                else if (i_cfg.in_valid) w_state_nxt = ST_LO;
            end
            ST_LO: begin
                if (i_cfg.abort) w_state_nxt = ST_IDLE;
                else if (w_tc)   w_state_nxt = ST_HI;
            end
            ST_HI: begin
                if (i_cfg.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tc) begin
                    if (r_bit_cnt != '0)        w_state_nxt = ST_LO;
                    else if (r_entry_idx != '0) w_state_nxt = ST_WAIT;
                    else                        w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transition strobes: every registered update below keys off a state change.
    assign w_launch     = (r_state == ST_IDLE) && (w_state_nxt == ST_WAIT);
    assign w_accept     = (r_state == ST_WAIT) && (w_state_nxt == ST_LO);
    assign w_shift      = (r_state == ST_HI)   && (w_state_nxt == ST_LO);
    assign w_next_entry = (r_state == ST_HI)   && (w_state_nxt == ST_WAIT);
    assign w_abort      = i_cfg.abort && (r_state != ST_IDLE);

    assign w_tmr_en   = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_tmr_load = (w_state_nxt != r_state) &&
                        ((w_state_nxt == ST_LO) || (w_state_nxt == ST_HI));

    cal_half_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_half_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_tmr_load),
        .i_en    (w_tmr_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_entry_idx <= IDX_W'(N_ENTRIES - 1);
            r_cal_clk   <= 1'b0;
            r_cal_dat   <= 1'b0;
            r_cal_ena   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cal_clk <= (w_state_nxt == ST_HI);
            r_busy    <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_LO) ||
                         (w_state_nxt == ST_HI);
            r_done    <= (w_state_nxt == ST_DONE);

            if (w_launch || w_abort)       r_cal_ena <= 1'b0;
            else if (w_state_nxt == ST_DONE) r_cal_ena <= 1'b1;

            if (w_launch)          r_entry_idx <= IDX_W'(N_ENTRIES - 1);
            else if (w_next_entry) r_entry_idx <= r_entry_idx - 1'b1;

            // cal_dat only moves as cal_clk falls (or before the first LO), so it is stable across each rise.
            if (w_accept) begin
                r_shreg   <= i_cfg.in_data;
                r_bit_cnt <= BIT_W'(N_LUT - 1);
                r_cal_dat <= i_cfg.in_data[N_LUT-1];
            end else if (w_shift) begin
                r_shreg   <= {r_shreg[N_LUT-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 1'b1;
                r_cal_dat <= r_shreg[N_LUT-2];
            end
        end
    end

    assign i_cfg.in_ready = (r_state == ST_WAIT);
    assign o_cal_clk      = r_cal_clk;
    assign o_cal_dat      = r_cal_dat;
    assign o_cal_ena      = r_cal_ena;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule
